// File: rtl/axi4_lite_master_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_arb_pkg                                                          |
// | Shared FSM state, AXI response codes and PROT default for the arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4
  } arb_state_t;

  localparam logic [1:0] C_RESP_OKAY    = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] C_RESP_DECERR  = 2'b11;
  localparam logic [2:0] C_PROT_DEFAULT = 3'b000;

  // First bus state entered after a command is accepted.
  function automatic arb_state_t issue_state(input logic write);
    return write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_master_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_master_arbiter_if                                                |
// | AXI4-Lite channel bundle with master and slave views.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface axi4_lite_master_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic [2:0]      awprot;
  logic            awready;

  logic [DW-1:0]   wdata;
  logic            wvalid;
  logic [DW/8-1:0] wstrb;
  logic            wready;

  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic [2:0]      arprot;
  logic            arready;

  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic [1:0]      rresp;
  logic            rready;

  modport master (
    output awaddr, awvalid, awprot,
    input  awready,
    output wdata, wvalid, wstrb,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arvalid, arprot,
    input  arready,
    input  rdata, rvalid, rresp,
    output rready
  );

  modport slave (
    input  awaddr, awvalid, awprot,
    output awready,
    input  wdata, wvalid, wstrb,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arvalid, arprot,
    output arready,
    output rdata, rvalid, rresp,
    input  rready
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_arb_rr                                                           |
// | Two-way round-robin grant: on a tie the requester not granted last wins.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi4_lite_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = valid[1];
    end
  end

  assign any = |valid;

endmodule
`default_nettype wire

// File: rtl/axi4_lite_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_master_arbiter                                                   |
// | Shares one AXI4-Lite master port between two single-beat requesters.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi4_lite_master_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic [1:0]    rsp0_resp,

  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [1:0]    rsp1_resp,

  axi4_lite_master_arbiter_if.master axi
);

  arb_state_t    r_state;
  logic          r_last_grant;
  logic          r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_resp;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_arvalid;
  logic          r_bready;
  logic          r_rready;
  logic [1:0]    r_rsp_valid;

  logic          w_grant;
  logic          w_any;
  logic          w_accept;
  logic          w_sel_write;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_aw_done;
  logic          w_w_done;

  axi4_lite_arb_rr u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .any        (w_any)
  );

  // Accept is decoded in the same cycle so a new command can overlap the rsp pulse.
  assign w_accept    = (r_state == ST_IDLE) && w_any && !reset;
  assign req0_ready  = w_accept && !w_grant;
  assign req1_ready  = w_accept &&  w_grant;

  assign w_sel_write = w_grant ? req1_write : req0_write;
  assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;

  // A channel counts as done once its valid has dropped or it handshakes now.
  assign w_aw_done   = !r_awvalid || axi.awready;
  assign w_w_done    = !r_wvalid  || axi.wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_resp       <= C_RESP_OKAY;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_valid  <= 2'b00;
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_state      <= issue_state(w_sel_write);
            if (w_sel_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_arvalid <= 1'b1;
            end
          end
        end

        ST_WR_ADDR_DATA: begin
          if (axi.awready) begin
            r_awvalid <= 1'b0;
          end
          if (axi.wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (r_bready && axi.bvalid) begin
            r_bready             <= 1'b0;
            r_resp               <= axi.bresp;
            r_rdata              <= '0;
            r_rsp_valid[r_owner] <= 1'b1;
            r_state              <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (r_rready && axi.rvalid) begin
            r_rready             <= 1'b0;
            r_rdata              <= axi.rdata;
            r_resp               <= axi.rresp;
            r_rsp_valid[r_owner] <= 1'b1;
            r_state              <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign axi.awaddr  = r_addr;
  assign axi.awvalid = r_awvalid;
  assign axi.awprot  = C_PROT_DEFAULT;
  assign axi.wdata   = r_wdata;
  assign axi.wvalid  = r_wvalid;
  assign axi.wstrb   = '1;
  assign axi.bready  = r_bready;
  assign axi.araddr  = r_addr;
  assign axi.arvalid = r_arvalid;
  assign axi.arprot  = C_PROT_DEFAULT;
  assign axi.rready  = r_rready;

  assign rsp0_valid  = r_rsp_valid[0];
  assign rsp1_valid  = r_rsp_valid[1];
  assign rsp0_rdata  = r_rdata;
  assign rsp1_rdata  = r_rdata;
  assign rsp0_resp   = r_resp;
  assign rsp1_resp   = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi4_lite_master_arbiter                                                |
// | Self-checking bench: requester drivers, AXI slave model, rsp scoreboard.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi4_lite_master_arbiter;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } cmd_t;

  typedef struct {
    bit          owner;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  slv_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic [1:0]  rsp0_resp;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [1:0]  rsp1_resp;

  axi4_lite_master_arbiter_if #(.AW(32), .DW(32)) axi ();

  axi4_lite_master_arbiter #(.DW(32), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_resp  (rsp0_resp),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_resp  (rsp1_resp),
    .axi        (axi)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- requester drivers + scoreboard push ----------------
  cmd_t q0[$], q1[$], sb0[$], sb1[$];
  bit   acc0 = 0, acc1 = 0;
  int   acc_cnt0 = 0, acc_cnt1 = 0, acc_cyc0 = 0, acc_cyc1 = 0;
  int   grant_log[$], acc_log[$];

  initial begin
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    forever begin
      @(negedge clk);
      if (acc0) begin q0.delete(0); acc0 = 0; end
      if (!reset && q0.size() > 0) begin
        req0_valid = 1; req0_write = q0[0].write; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
      end else begin
        req0_valid = 0;
      end
      #1;
      if (req0_valid && req0_ready) begin
        acc0 = 1; sb0.push_back(q0[0]); acc_cyc0 = cyc; acc_cnt0++;
        grant_log.push_back(0); acc_log.push_back(cyc);
      end
    end
  end

  initial begin
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    forever begin
      @(negedge clk);
      if (acc1) begin q1.delete(0); acc1 = 0; end
      if (!reset && q1.size() > 0) begin
        req1_valid = 1; req1_write = q1[0].write; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
      end else begin
        req1_valid = 0;
      end
      #1;
      if (req1_valid && req1_ready) begin
        acc1 = 1; sb1.push_back(q1[0]); acc_cyc1 = cyc; acc_cnt1++;
        grant_log.push_back(1); acc_log.push_back(cyc);
      end
    end
  end

  // ---------------- response monitor (scoreboard pop) ----------------
  int rsp_cnt0 = 0, rsp_cnt1 = 0, rsp_cyc0 = 0, rsp_cyc1 = 0;
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rsp0_valid) begin
        rsp_cnt0++; rsp_cyc0 = cyc;
        chk("rsp0_expected", (sb0.size() != 0), 1);
        if (sb0.size() != 0) begin
          e = sb0.pop_front();
          chk("rsp0_rdata", rsp0_rdata, e.exp_rdata);
          chk("rsp0_resp", rsp0_resp, e.exp_resp);
        end
      end
      if (rsp1_valid) begin
        rsp_cnt1++; rsp_cyc1 = cyc;
        chk("rsp1_expected", (sb1.size() != 0), 1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          chk("rsp1_rdata", rsp1_rdata, e.exp_rdata);
          chk("rsp1_resp", rsp1_resp, e.exp_resp);
        end
      end
    end
  end

  // ---------------- AXI4-Lite slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit b_hold = 0, cfg_rovr = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int aw_cnt, w_cnt, ar_cnt, aw_hs, w_hs, ar_hs, b_hs, r_hs, b_issued;
  int aw_cyc, ar_cyc;
  bit b_fire, r_fire;
  logic [31:0] log_awaddr, log_wdata, log_araddr;
  logic [3:0]  log_wstrb;
  logic [2:0]  log_awprot, log_arprot;
  logic [31:0] arq[$];

  initial begin
    logic [31:0] a;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
        b_hs = 0; r_hs = 0; b_issued = 0; b_fire = 0; r_fire = 0; arq.delete();
      end else begin
        if (b_fire) begin axi.bvalid = 0; b_fire = 0; end
        if (r_fire) begin axi.rvalid = 0; r_fire = 0; end
        if (!axi.bvalid && !b_hold && b_issued < aw_hs && b_issued < w_hs) begin
          axi.bvalid = 1; axi.bresp = cfg_bresp; b_issued++;
        end
        if (axi.bvalid && axi.bready) begin b_fire = 1; b_hs++; end
        if (!axi.rvalid && arq.size() > 0) begin
          a = arq.pop_front();
          axi.rvalid = 1; axi.rdata = cfg_rovr ? cfg_rdata : mem_f(a); axi.rresp = cfg_rresp;
        end
        if (axi.rvalid && axi.rready) begin r_fire = 1; r_hs++; end
        if (axi.awvalid) begin
          axi.awready = (aw_cnt >= aw_delay); aw_cnt++;
          if (axi.awready) begin
            aw_hs++; aw_cyc = cyc; log_awaddr = axi.awaddr; log_awprot = axi.awprot;
          end
        end else begin
          axi.awready = 0; aw_cnt = 0;
        end
        if (axi.wvalid) begin
          axi.wready = (w_cnt >= w_delay); w_cnt++;
          if (axi.wready) begin
            w_hs++; log_wdata = axi.wdata; log_wstrb = axi.wstrb;
          end
        end else begin
          axi.wready = 0; w_cnt = 0;
        end
        if (axi.arvalid) begin
          axi.arready = (ar_cnt >= ar_delay); ar_cnt++;
          if (axi.arready) begin
            ar_hs++; ar_cyc = cyc; log_araddr = axi.araddr; log_arprot = axi.arprot;
            arq.push_back(axi.araddr);
          end
        end else begin
          axi.arready = 0; ar_cnt = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic cmd_t mk_cmd(bit write, logic [31:0] addr, logic [31:0] wdata,
                                  logic [31:0] er, logic [1:0] eresp);
    cmd_t c;
    c.write = write; c.addr = addr; c.wdata = wdata; c.exp_rdata = er; c.exp_resp = eresp;
    return c;
  endfunction

  function automatic vec_t mk_vec(bit owner, bit write, logic [31:0] addr, logic [31:0] wdata,
                                  logic [1:0] slv, logic [31:0] er, logic [1:0] eresp);
    vec_t v;
    v.owner = owner; v.write = write; v.addr = addr; v.wdata = wdata;
    v.slv_resp = slv; v.exp_rdata = er; v.exp_resp = eresp;
    return v;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb0.size() != 0 || sb1.size() != 0 || acc0 || acc1)
           && n < 300) begin
      @(negedge clk); #3; n++;
    end
    chk({"idle_", tag}, (n < 300), 1);
  endtask

  task automatic wait_acc(input bit who, input int prev);
    int n = 0;
    while (((who ? acc_cnt1 : acc_cnt0) == prev) && n < 100) begin
      @(negedge clk); #2; n++;
    end
    chk("accept_wait", (n < 100), 1);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[6];

  initial begin
    int s0, s1, sb, saw, sw;
    vecs[0] = mk_vec(0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 32'h0000_0000, 2'd0);
    vecs[1] = mk_vec(1, 0, 32'h0000_2000, 32'h0,         2'd0, 32'h5A5A_2000, 2'd0);
    vecs[2] = mk_vec(0, 1, 32'h0000_3004, 32'h0BAD_F00D, 2'd2, 32'h0000_0000, 2'd2);
    vecs[3] = mk_vec(1, 0, 32'h0000_0040, 32'h0,         2'd3, 32'h5A5A_0040, 2'd3);
    vecs[4] = mk_vec(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, 2'd0);
    vecs[5] = mk_vec(0, 0, 32'hFFFF_FFFC, 32'h0,         2'd0, 32'hA5A5_FFFC, 2'd0);

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    chk("rst_ready_rsp", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0);
    chk("rst_awaddr", axi.awaddr, 32'h0);
    chk("rst_wdata", axi.wdata, 32'h0);
    chk("rst_rsp_data", {rsp0_rdata, rsp0_resp}, 34'h0);
    @(negedge clk);
    reset = 0;

    // Continuous contention: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk_cmd(0, 32'h100 + 4 * i, 0, mem_f(32'h100 + 4 * i), 2'd0));
      q1.push_back(mk_cmd(0, 32'h200 + 4 * i, 0, mem_f(32'h200 + 4 * i), 2'd0));
    end
    wait_idle("alternate");
    chk("grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], i % 2);
    for (int i = 1; i < 8 && i < acc_log.size(); i++) chk("b2b_spacing", acc_log[i] - acc_log[i-1], 3);

    // Table-driven single transactions against a zero-wait slave
    for (int i = 0; i < 6; i++) begin
      cfg_bresp = vecs[i].slv_resp;
      cfg_rresp = vecs[i].slv_resp;
      if (vecs[i].owner)
        q1.push_back(mk_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_resp));
      else
        q0.push_back(mk_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_resp));
      wait_idle("vec");
      if (vecs[i].owner) begin
        chk("vec_latency", rsp_cyc1 - acc_cyc1, 3);
        chk("vec_bus_cycle", (vecs[i].write ? aw_cyc : ar_cyc) - acc_cyc1, 1);
      end else begin
        chk("vec_latency", rsp_cyc0 - acc_cyc0, 3);
        chk("vec_bus_cycle", (vecs[i].write ? aw_cyc : ar_cyc) - acc_cyc0, 1);
      end
      if (vecs[i].write) begin
        chk("vec_awaddr", log_awaddr, vecs[i].addr);
        chk("vec_wdata", log_wdata, vecs[i].wdata);
        chk("vec_wstrb_prot", {log_wstrb, log_awprot}, {4'hF, 3'b000});
      end else begin
        chk("vec_araddr", log_araddr, vecs[i].addr);
        chk("vec_arprot", log_arprot, 3'b000);
      end
    end
    cfg_bresp = 0; cfg_rresp = 0;

    // W handshake well before AW
    aw_delay = 5; w_delay = 1;
    s0 = rsp_cnt0; sb = b_hs; saw = aw_hs; sw = w_hs;
    q0.push_back(mk_cmd(1, 32'h0000_1100, 32'hCAFE_F00D, 32'h0, 2'd0));
    wait_acc(0, acc_cnt0);
    repeat (3) @(negedge clk);
    #1;
    chk("w_first_wvalid_low", axi.wvalid, 1'b0);
    chk("w_first_awvalid_held", {axi.awvalid, axi.awaddr}, {1'b1, 32'h0000_1100});
    wait_idle("w_first");
    chk("w_first_hs_counts", {aw_hs - saw, w_hs - sw, b_hs - sb}, {32'd1, 32'd1, 32'd1});
    chk("w_first_rsp_count", rsp_cnt0 - s0, 1);
    chk("w_first_wdata", log_wdata, 32'hCAFE_F00D);
    aw_delay = 0; w_delay = 0;

    // Error read response for requester 1
    cfg_rresp = 2'd2; cfg_rovr = 1; cfg_rdata = 32'h1234_5678;
    s0 = rsp_cnt0; s1 = rsp_cnt1;
    q1.push_back(mk_cmd(0, 32'h0000_0800, 32'h0, 32'h1234_5678, 2'd2));
    wait_idle("slverr");
    chk("slverr_rsp0_quiet", rsp_cnt0 - s0, 0);
    chk("slverr_rsp1_count", rsp_cnt1 - s1, 1);
    cfg_rresp = 0; cfg_rovr = 0;

    // Long ARREADY stall with a pending competitor
    ar_delay = 20;
    q1.push_back(mk_cmd(0, 32'h0000_0500, 32'h0, 32'h5A5A_0500, 2'd0));
    wait_acc(1, acc_cnt1);
    q0.push_back(mk_cmd(0, 32'h0000_0600, 32'h0, 32'h5A5A_0600, 2'd0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      chk("ar_stall_hold", {axi.arvalid, axi.araddr, req0_ready}, {1'b1, 32'h0000_0500, 1'b0});
    end
    wait_idle("ar_stall");
    chk("ar_stall_next_accept", acc_cyc0 - rsp_cyc1, 0);
    ar_delay = 0;

    // Reset while waiting for a withheld write response
    b_hold = 1;
    q0.push_back(mk_cmd(1, 32'h0000_0900, 32'h1111_2222, 32'h0, 2'd0));
    wait_acc(0, acc_cnt0);
    begin
      int n = 0;
      while (!axi.bready && n < 20) begin @(negedge clk); #2; n++; end
      chk("wr_resp_reached", axi.bready, 1'b1);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("async_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    chk("async_rst_ready_rsp", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0);
    chk("async_rst_addr_data", {axi.awaddr, axi.wdata}, 64'h0);
    sb0.delete();
    repeat (2) @(negedge clk);
    reset = 0; b_hold = 0;
    s0 = rsp_cnt0; s1 = rsp_cnt1;
    q1.push_back(mk_cmd(0, 32'h0000_0A00, 32'h0, 32'h5A5A_0A00, 2'd0));
    wait_idle("post_reset");
    chk("post_reset_rsp0_quiet", rsp_cnt0 - s0, 0);
    chk("post_reset_rsp1_count", rsp_cnt1 - s1, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_master_arbiter.md
# axi4_lite_master_arbiter

Shares one AXI4-Lite master port between two on-chip requesters (e.g. a capture-control FSM and a host-driven register bridge), issuing one single-beat read or write at a time. Requesters use a simple valid/ready command interface plus a one-cycle response pulse. Round-robin arbitration prevents starvation. The AXI side connects directly to an AXI4-Lite slave or interconnect port.

## Interface
- DW, 32, AXI data width (bits).
- AW, 32, AXI address width (bits).
- clk  in  1  clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  requester N (N = 0,1) has a command pending; held until reqN_ready.
- reqN_write  in  1  1 = write, 0 = read; stable while reqN_valid.
- reqN_addr  in  AW  byte address.
- reqN_wdata  in  DW  write data (ignored for reads).
- reqN_ready  out  1  one-cycle accept pulse; command is latched on this cycle.
- rspN_valid  out  1  one-cycle completion pulse.
- rspN_rdata  out  DW  read data (0 for writes), valid with rspN_valid.
- rspN_resp  out  2  BRESP/RRESP of the transaction, valid with rspN_valid.
- AXI_AWADDR/AWVALID/AWPROT/AWREADY, AXI_WDATA/WVALID/WSTRB/WREADY, AXI_BRESP/BVALID/BREADY, AXI_ARADDR/ARVALID/ARPROT/ARREADY, AXI_RDATA/RVALID/RRESP/RREADY: standard AXI4-Lite master channels, widths per AW/DW.

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: if any reqN_valid, grant per round-robin, pulse reqN_ready, latch write/addr/wdata and owner index; go WR_ADDR_DATA (write) or RD_ADDR (read).
- Round robin: last_grant register. Both valid -> grant the index != last_grant. One valid -> grant it. last_grant updates on every grant.
- WR_ADDR_DATA: AWVALID and WVALID both asserted; each drops independently on its own handshake (AWVALID&AWREADY, WVALID&WREADY), in either order or the same cycle. When both are done -> WR_RESP.
- WR_RESP: BREADY=1; on BVALID, latch BRESP, rdata=0 -> IDLE.
- RD_ADDR: ARVALID=1 until ARREADY -> RD_DATA. RD_DATA: RREADY=1; on RVALID latch RDATA/RRESP -> IDLE.
- Completion: rspN_valid pulses for the latched owner only, for exactly one cycle.
- AWPROT = ARPROT = 3'b000. WSTRB = all ones. AWADDR/ARADDR/WDATA are driven from latched registers and stay stable while VALID is high.
- Error responses (SLVERR/DECERR) pass through unchanged. No retry, no timeout.
- Nothing is accepted outside IDLE. reqN_valid held during a busy period waits; it is never dropped or reordered.

## Timing
- Reset (async assert, sync release): FSM=IDLE, last_grant=1 (so requester 0 wins first tie). All VALID/READY outputs, reqN_ready and rspN_valid are 0. Latched addr/data/rdata/resp are 0.
- Cycle 0: accept (reqN_ready=1). Cycle 1: first cycle with AWVALID/WVALID or ARVALID high.
- Zero-wait slave write: AW+W handshake cycle 1, BVALID cycle 2, rspN_valid cycle 3. Read likewise: AR cycle 1, R cycle 2, rsp cycle 3.
- FSM is in IDLE during the rspN_valid cycle, so the next accept can coincide with it. Back-to-back throughput is one transaction per 3 cycles.
- BREADY/RREADY are high only in WR_RESP/RD_DATA. Early BVALID/RVALID in other states are not consumed.
- Reset mid-transaction abandons it: VALIDs drop immediately and no rsp pulse is issued.

## Structure
- Package axi4_lite_arb_pkg: FSM state enum, AXI resp constants (OKAY=0, SLVERR=2, DECERR=3), PROT default.
- One sub-module: axi4_lite_arb_rr (2-way round-robin grant: inputs valids + last_grant, output grant index + any). Everything else stays in the top level.

## Test plan
- Single write from req0, addr 0x1000, data 0xDEADBEEF, zero-wait slave -> AW/W in cycle 1 with those values, WSTRB=0xF, rsp0_valid in cycle 3, rsp0_resp=0.
- W handshake 4 cycles before AW (AWREADY delayed 5 cycles) -> WVALID drops after its handshake, AWVALID held. Exactly one B accepted, one rsp0 pulse.
- req0 and req1 held valid continuously with reads -> grants alternate 0,1,0,1. First grant is 0 after reset. Each rspN_rdata matches the slave RDATA for its address.
- Read returning RRESP=2, RDATA=0x12345678 for req1 -> rsp1_resp=2, rsp1_rdata=0x12345678, rsp0_valid stays 0.
- Reset asserted while in WR_RESP with BVALID withheld -> all outputs 0 asynchronously. After release, a req1 read completes normally with no spurious rsp.
- ARREADY held low 20 cycles -> ARVALID/ARADDR stable all 20 cycles, and req0_ready stays 0 for a pending req0 until rsp1 completes.
